inhibitor_bank: RTL and testbench

Multi-channel registered successor to the single-bit combinational inhibitor. Each of WIDTH channels passes `in` to `out` unless inhibited by its own active-low-named inhibit line or by a global one. After an inhibit is released, the channel stays gated for a programmable hold-off before re-arming. The block also keeps a saturating count, per channel, of suppressed 1-samples. It sits between raw event/request sources and downstream logic that must be blanked during and shortly after inhibit windows.

---
 rtl/inhibitor_bank.sv | 115 +++++++++++
 tb/tb_inhibitor_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/inhibitor_bank.sv
// Multi-channel registered inhibitor with per-channel re-arm hold-off and
// saturating per-channel counters of suppressed 1-samples.
module inhibitor_bank #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned HOLDOFF = 4,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned SEL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] enable_l,
  input  logic             global_enable_l,
  input  logic [SEL_W-1:0] count_sel,
  input  logic             count_clr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] inhibited,
  output logic [CNT_W-1:0] blocked_count
);

  localparam int unsigned HC_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    INHIBIT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [HC_W-1:0]  hcnt_q  [WIDTH];
  logic [HC_W-1:0]  hcnt_d  [WIDTH];
  logic [CNT_W-1:0] bcnt_q  [WIDTH];
  logic [CNT_W-1:0] bcnt_d  [WIDTH];
  logic [WIDTH-1:0] eff_inh;
  logic [WIDTH-1:0] pass_d;

  assign eff_inh = enable_l | {WIDTH{global_enable_l}};

  // Per-channel next state, hold countdown and blocked-event counting
  always_comb begin
    pass_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      hcnt_d[i]  = hcnt_q[i];
      bcnt_d[i]  = bcnt_q[i];

      case (state_q[i])
        PASS: begin
          if (eff_inh[i]) state_d[i] = INHIBIT;
        end
        INHIBIT: begin
          if (!eff_inh[i]) begin
            if (HOLDOFF == 0) begin
              state_d[i] = PASS;
            end else begin
              state_d[i] = HOLD;
              hcnt_d[i]  = HC_W'(HOLDOFF - 1);
            end
          end
        end
        HOLD: begin
          if (eff_inh[i]) begin
            state_d[i] = INHIBIT;
            hcnt_d[i]  = '0;
          end else if (hcnt_q[i] == '0) begin
            state_d[i] = PASS;
          end else begin
            hcnt_d[i] = hcnt_q[i] - HC_W'(1);
          end
        end
        default: state_d[i] = INHIBIT;
      endcase

      pass_d[i] = (state_d[i] == PASS);

      if (in[i] && !pass_d[i] && (bcnt_q[i] != '1)) begin
        bcnt_d[i] = bcnt_q[i] + CNT_W'(1);
      end
      // Clear wins over a same-edge increment; out-of-range selects match nothing
      if (count_clr && (count_sel == SEL_W'(i))) begin
        bcnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= INHIBIT;
        hcnt_q[i]  <= '0;
        bcnt_q[i]  <= '0;
      end
      out       <= '0;
      inhibited <= '1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        hcnt_q[i]  <= hcnt_d[i];
        bcnt_q[i]  <= bcnt_d[i];
      end
      out       <= in & pass_d;
      inhibited <= ~pass_d;
    end
  end

  // Counter read port; selects beyond the last channel read as zero
  always_comb begin
    blocked_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (count_sel == SEL_W'(i)) blocked_count = bcnt_q[i];
    end
  end

endmodule

// File: tb/tb_inhibitor_bank.sv
// Directed bench: default-parameter bank plus a small HOLDOFF=0 bank used
// for zero-hold behaviour and out-of-range counter select.
module tb_inhibitor_bank;

  logic       clk = 1'b0;
  logic       reset;

  logic [7:0] in_a, en_a, out_a, inh_a, bc_a;
  logic       gl_a, clr_a;
  logic [2:0] sel_a;

  logic [4:0] in_b, en_b, out_b, inh_b;
  logic       gl_b, clr_b;
  logic [2:0] sel_b;
  logic [3:0] bc_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inhibitor_bank #(.WIDTH(8), .HOLDOFF(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in(in_a), .enable_l(en_a),
    .global_enable_l(gl_a), .count_sel(sel_a), .count_clr(clr_a),
    .out(out_a), .inhibited(inh_a), .blocked_count(bc_a)
  );

  inhibitor_bank #(.WIDTH(5), .HOLDOFF(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .in(in_b), .enable_l(en_b),
    .global_enable_l(gl_b), .count_sel(sel_b), .count_clr(clr_b),
    .out(out_b), .inhibited(inh_b), .blocked_count(bc_b)
  );

  typedef struct {
    logic [7:0] in_v;
    logic [7:0] en_v;
    logic       gl;
    logic [7:0] eo;
    logic [7:0] ei;
  } vec_t;

  vec_t va [28];
  vec_t vb [5];

  function automatic vec_t mk(logic [7:0] i, logic [7:0] e, logic g,
                              logic [7:0] o, logic [7:0] h);
    vec_t v;
    v.in_v = i; v.en_v = e; v.gl = g; v.eo = o; v.ei = h;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_a(input int k);
    in_a = va[k].in_v; en_a = va[k].en_v; gl_a = va[k].gl;
    step();
    chk($sformatf("va%0d.out", k), 32'(out_a), 32'(va[k].eo));
    chk($sformatf("va%0d.inh", k), 32'(inh_a), 32'(va[k].ei));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // Power-up blanking, release and steady pass
    for (int k = 0; k < 4; k++) va[k] = mk(8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF);
    va[4]  = mk(8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00);
    // Channel 0 inhibit, 4-edge hold, pass, then input low
    va[5]  = mk(8'hFF, 8'h01, 1'b0, 8'hFE, 8'h01);
    for (int k = 6; k < 10; k++) va[k] = mk(8'hFF, 8'h00, 1'b0, 8'hFE, 8'h01);
    va[10] = mk(8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00);
    va[11] = mk(8'hFE, 8'h00, 1'b0, 8'hFE, 8'h00);
    // One-edge global pulse
    va[12] = mk(8'hA5, 8'h00, 1'b1, 8'h00, 8'hFF);
    for (int k = 13; k < 17; k++) va[k] = mk(8'hA5, 8'h00, 1'b0, 8'h00, 8'hFF);
    va[17] = mk(8'hA5, 8'h00, 1'b0, 8'hA5, 8'h00);
    va[18] = mk(8'hA5, 8'h00, 1'b0, 8'hA5, 8'h00);
    // Channel 2 re-inhibited mid-hold restarts the full hold-off
    va[19] = mk(8'hFF, 8'h04, 1'b0, 8'hFB, 8'h04);
    va[20] = mk(8'hFF, 8'h00, 1'b0, 8'hFB, 8'h04);
    va[21] = mk(8'hFF, 8'h00, 1'b0, 8'hFB, 8'h04);
    va[22] = mk(8'hFF, 8'h04, 1'b0, 8'hFB, 8'h04);
    for (int k = 23; k < 27; k++) va[k] = mk(8'hFF, 8'h00, 1'b0, 8'hFB, 8'h04);
    va[27] = mk(8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00);

    // Zero hold-off: out = in & ~eff_inh one edge later
    vb[0] = mk(8'h1F, 8'h00, 1'b0, 8'h1F, 8'h00);
    vb[1] = mk(8'h15, 8'h04, 1'b0, 8'h11, 8'h04);
    vb[2] = mk(8'h0A, 8'h00, 1'b1, 8'h00, 8'h1F);
    vb[3] = mk(8'h1B, 8'h03, 1'b0, 8'h18, 8'h03);
    vb[4] = mk(8'h1F, 8'h00, 1'b0, 8'h1F, 8'h00);

    reset = 1'b1;
    in_a = 8'hFF; en_a = 8'h00; gl_a = 1'b0; sel_a = 3'd3; clr_a = 1'b0;
    in_b = 5'h00; en_b = 5'h00; gl_b = 1'b0; sel_b = 3'd4; clr_b = 1'b0;
    #3;
    chk("rst.out", 32'(out_a), 32'h00);
    chk("rst.inh", 32'(inh_a), 32'hFF);
    chk("rst.bc",  32'(bc_a),  32'h00);
    #9;
    reset = 1'b0;

    for (int k = 0; k < 28; k++) apply_a(k);

    for (int k = 0; k < 5; k++) begin
      in_b = vb[k].in_v[4:0]; en_b = vb[k].en_v[4:0]; gl_b = vb[k].gl;
      step();
      chk($sformatf("vb%0d.out", k), 32'(out_b), 32'(vb[k].eo));
      chk($sformatf("vb%0d.inh", k), 32'(inh_b), 32'(vb[k].ei));
    end

    // Small bank: 4-bit saturation and out-of-range clear/read
    in_b = 5'h1F; en_b = 5'h1F; gl_b = 1'b0;
    repeat (3) step();
    chk("b.bc3", 32'(bc_b), 32'd3);
    repeat (17) step();
    chk("b.bcsat", 32'(bc_b), 32'd15);
    en_b = 5'h00; sel_b = 3'd6; clr_b = 1'b1;
    step();
    chk("b.bcsel6", 32'(bc_b), 32'd0);
    clr_b = 1'b0; sel_b = 3'd4;
    #1;
    chk("b.noclr", 32'(bc_b), 32'd15);
    sel_b = 3'd7;
    #1;
    chk("b.bcsel7", 32'(bc_b), 32'd0);

    // Default bank: counter clear, count, saturate, clear-beats-increment
    sel_a = 3'd3; clr_a = 1'b1;
    step();
    chk("a.clr0", 32'(bc_a), 32'd0);
    clr_a = 1'b0; en_a = 8'h09;
    repeat (10) step();
    chk("a.bc10", 32'(bc_a), 32'd10);
    chk("a.out09", 32'(out_a), 32'hF6);
    repeat (290) step();
    chk("a.bcsat", 32'(bc_a), 32'd255);
    sel_a = 3'd0;
    #1;
    chk("a.bc0sat", 32'(bc_a), 32'd255);
    sel_a = 3'd3; clr_a = 1'b1;
    step();
    chk("a.clrblk", 32'(bc_a), 32'd0);
    sel_a = 3'd0;
    #1;
    chk("a.otherkept", 32'(bc_a), 32'd255);
    sel_a = 3'd3; clr_a = 1'b0;
    step();
    chk("a.bc1", 32'(bc_a), 32'd1);

    // Asynchronous reset while channels 0 and 3 are in hold
    en_a = 8'h00;
    repeat (2) step();
    chk("a.holdinh", 32'(inh_a), 32'h09);
    chk("a.holdbc", 32'(bc_a), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.out", 32'(out_a), 32'h00);
    chk("arst.inh", 32'(inh_a), 32'hFF);
    chk("arst.bc",  32'(bc_a),  32'h00);
    reset = 1'b0;
    in_a = 8'hFF; en_a = 8'h00; gl_a = 1'b0;
    for (int k = 0; k < 5; k++) apply_a(k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
